// File: rtl/id_ex_hazard_regs.sv
// IF/ID and ID/EX pipeline registers driven by load-use stall and branch flush controls.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module id_ex_hazard_regs #(
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 8,
  parameter int MAX_STALL = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   IF_PC,
  input  logic [31:0]       IF_instr,
  input  logic              IF_ID_write,
  input  logic              NoOp,
  input  logic              Flush,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              ID_MemRead,
  input  logic [4:0]        ID_Rs1,
  input  logic [4:0]        ID_Rs2,
  input  logic [4:0]        ID_Rd,
  output logic [XLEN-1:0]   ID_PC,
  output logic [31:0]       ID_instr,
  output logic              ID_valid,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic              EX_MemRead,
  output logic [4:0]        EX_Rd,
  output logic [4:0]        EX_Rs1,
  output logic [4:0]        EX_Rs2,
  output logic              EX_valid,
  output logic [1:0]        state_o,
  output logic              proto_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  logic [XLEN-1:0]   idPc_q, idPc_d;
  logic [31:0]       idInstr_q, idInstr_d;
  logic              idValid_q, idValid_d;
  logic [CTRL_W-1:0] exCtrl_q, exCtrl_d;
  logic              exMemRead_q, exMemRead_d;
  logic [4:0]        exRd_q, exRd_d;
  logic [4:0]        exRs1_q, exRs1_d;
  logic [4:0]        exRs2_q, exRs2_d;
  logic              exValid_q, exValid_d;
  logic [RUN_W-1:0]  stallRun_q, stallRun_d;
  logic              protoErr_q, protoErr_d;
  state_e            state_q;

  logic stallEdge;
  logic bubble;
  logic overStall;

  // Flush outranks NoOp everywhere, so a stall edge only exists without Flush.
  assign stallEdge = NoOp & ~Flush;
  assign bubble    = Flush | NoOp | ~idValid_q;
  assign overStall = stallEdge & (stallRun_q >= RUN_LIMIT);

  always_comb begin
    idPc_d    = idPc_q;
    idInstr_d = idInstr_q;
    idValid_d = idValid_q;
    if (Flush) begin
      idInstr_d = NOP_INSTR;
      idValid_d = 1'b0;
    end else if (IF_ID_write) begin
      idPc_d    = IF_PC;
      idInstr_d = IF_instr;
      idValid_d = 1'b1;
    end
  end

  always_comb begin
    exCtrl_d    = '0;
    exMemRead_d = 1'b0;
    exRd_d      = '0;
    exRs1_d     = '0;
    exRs2_d     = '0;
    exValid_d   = 1'b0;
    if (!bubble) begin
      exCtrl_d    = ID_ctrl;
      exMemRead_d = ID_MemRead;
      exRd_d      = ID_Rd;
      exRs1_d     = ID_Rs1;
      exRs2_d     = ID_Rs2;
      exValid_d   = 1'b1;
    end
  end

  // The run length saturates just past the limit so long stalls cannot wrap back under it.
  always_comb begin
    stallRun_d = '0;
    if (stallEdge) begin
      stallRun_d = (stallRun_q >= RUN_SAT) ? RUN_SAT : stallRun_q + 1'b1;
    end
    protoErr_d = protoErr_q | (stallEdge & IF_ID_write) | overStall;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idPc_q      <= '0;
      idInstr_q   <= NOP_INSTR;
      idValid_q   <= 1'b0;
      exCtrl_q    <= '0;
      exMemRead_q <= 1'b0;
      exRd_q      <= '0;
      exRs1_q     <= '0;
      exRs2_q     <= '0;
      exValid_q   <= 1'b0;
      stallRun_q  <= '0;
      protoErr_q  <= 1'b0;
    end else begin
      idPc_q      <= idPc_d;
      idInstr_q   <= idInstr_d;
      idValid_q   <= idValid_d;
      exCtrl_q    <= exCtrl_d;
      exMemRead_q <= exMemRead_d;
      exRd_q      <= exRd_d;
      exRs1_q     <= exRs1_d;
      exRs2_q     <= exRs2_d;
      exValid_q   <= exValid_d;
      stallRun_q  <= stallRun_d;
      protoErr_q  <= protoErr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Flush)          state_q <= ST_FLUSH;
          else if (NoOp)      state_q <= ST_STALL;
          else                state_q <= ST_RUN;
        end
        ST_STALL: begin
          if (Flush)          state_q <= ST_FLUSH;
          else if (NoOp)      state_q <= ST_STALL;
          else                state_q <= ST_RUN;
        end
        ST_FLUSH: begin
          if (Flush)          state_q <= ST_FLUSH;
          else if (NoOp)      state_q <= ST_STALL;
          else                state_q <= ST_RUN;
        end
        default:              state_q <= ST_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stallEdge && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 1'b1;
    if (Flush && (flushCnt_q != '1))     flushCnt_d = flushCnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign ID_PC      = idPc_q;
  assign ID_instr   = idInstr_q;
  assign ID_valid   = idValid_q;
  assign EX_ctrl    = exCtrl_q;
  assign EX_MemRead = exMemRead_q;
  assign EX_Rd      = exRd_q;
  assign EX_Rs1     = exRs1_q;
  assign EX_Rs2     = exRs2_q;
  assign EX_valid   = exValid_q;
  assign state_o    = state_q;
  assign proto_err  = protoErr_q;

endmodule

// File: tb/tb_id_ex_hazard_regs.sv
// Directed bench for id_ex_hazard_regs: stall, flush, reset and protocol-error scenarios.
module tb_id_ex_hazard_regs;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [XLEN-1:0]   IF_PC;
  logic [31:0]       IF_instr;
  logic              IF_ID_write, NoOp, Flush;
  logic [CTRL_W-1:0] ID_ctrl;
  logic              ID_MemRead;
  logic [4:0]        ID_Rs1, ID_Rs2, ID_Rd;
  logic [XLEN-1:0]   ID_PC;
  logic [31:0]       ID_instr;
  logic              ID_valid;
  logic [CTRL_W-1:0] EX_ctrl;
  logic              EX_MemRead;
  logic [4:0]        EX_Rd, EX_Rs1, EX_Rs2;
  logic              EX_valid;
  logic [1:0]        state_o;
  logic              proto_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checkCount = 0;
  int passCount  = 0;

  id_ex_hazard_regs #(.XLEN(XLEN), .CTRL_W(CTRL_W), .MAX_STALL(1), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .IF_PC(IF_PC), .IF_instr(IF_instr),
    .IF_ID_write(IF_ID_write), .NoOp(NoOp), .Flush(Flush), .ID_ctrl(ID_ctrl),
    .ID_MemRead(ID_MemRead), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
    .ID_PC(ID_PC), .ID_instr(ID_instr), .ID_valid(ID_valid), .EX_ctrl(EX_ctrl),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_Rs1(EX_Rs1), .EX_Rs2(EX_Rs2),
    .EX_valid(EX_valid), .state_o(state_o), .proto_err(proto_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Drive one edge worth of control inputs, then sample 1ns after the edge.
  task automatic applyStimulus(input logic wr, input logic noop, input logic flush,
                               input logic [31:0] pc, input logic [31:0] instr);
    IF_ID_write = wr;
    NoOp        = noop;
    Flush       = flush;
    IF_PC       = pc;
    IF_instr    = instr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    rst_i = 1'b1;
    IF_ID_write = 1'b0; NoOp = 1'b0; Flush = 1'b0;
    IF_PC = '0; IF_instr = '0;
    ID_ctrl = 8'h5A; ID_MemRead = 1'b1; ID_Rs1 = 5'd1; ID_Rs2 = 5'd2; ID_Rd = 5'd3;
    #12;
    checkOutput("rst_id_pc", ID_PC, 0);
    checkOutput("rst_id_instr", ID_instr, 32'h13);
    checkOutput("rst_id_valid", ID_valid, 0);
    checkOutput("rst_ex_valid", EX_valid, 0);
    checkOutput("rst_ex_ctrl", EX_ctrl, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_proto", proto_err, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_flush_cnt", flush_cnt, 0);
    rst_i = 1'b0;

    applyStimulus(1, 0, 0, 32'h100, 32'h0050_0113);
    checkOutput("load_id_pc", ID_PC, 32'h100);
    checkOutput("load_id_instr", ID_instr, 32'h0050_0113);
    checkOutput("load_id_valid", ID_valid, 1);
    checkOutput("load_ex_bubble", EX_valid, 0);

    applyStimulus(1, 0, 0, 32'h104, 32'h00A0_0093);
    checkOutput("pipe_id_pc", ID_PC, 32'h104);
    checkOutput("pipe_ex_valid", EX_valid, 1);
    checkOutput("pipe_ex_ctrl", EX_ctrl, 8'h5A);
    checkOutput("pipe_ex_memread", EX_MemRead, 1);
    checkOutput("pipe_ex_rd", EX_Rd, 3);
    checkOutput("pipe_ex_rs1", EX_Rs1, 1);
    checkOutput("pipe_ex_rs2", EX_Rs2, 2);

    applyStimulus(0, 1, 0, 32'h108, 32'h0000_0033);
    checkOutput("stall_id_pc_held", ID_PC, 32'h104);
    checkOutput("stall_id_instr_held", ID_instr, 32'h00A0_0093);
    checkOutput("stall_id_valid", ID_valid, 1);
    checkOutput("stall_ex_valid", EX_valid, 0);
    checkOutput("stall_ex_rd", EX_Rd, 0);
    checkOutput("stall_ex_memread", EX_MemRead, 0);
    checkOutput("stall_state", state_o, 2'b01);

    ID_ctrl = 8'h11; ID_MemRead = 1'b0; ID_Rd = 5'd4;
    applyStimulus(1, 0, 0, 32'h108, 32'h0000_0033);
    checkOutput("resume_state", state_o, 2'b00);
    checkOutput("resume_proto", proto_err, 0);
    checkOutput("resume_ex_valid", EX_valid, 1);
    checkOutput("resume_ex_rd", EX_Rd, 4);
    checkOutput("resume_ex_ctrl", EX_ctrl, 8'h11);
    checkOutput("resume_stall_cnt", stall_cnt, PERF ? 1 : 0);

    #3 rst_i = 1'b1;
    #1;
    checkOutput("midrst_ex_valid", EX_valid, 0);
    checkOutput("midrst_id_instr", ID_instr, 32'h13);
    checkOutput("midrst_id_pc", ID_PC, 0);
    checkOutput("midrst_state", state_o, 0);
    checkOutput("midrst_stall_cnt", stall_cnt, 0);
    rst_i = 1'b0;

    applyStimulus(1, 0, 0, 32'h200, 32'h0010_0093);
    checkOutput("reload_id_valid", ID_valid, 1);

    applyStimulus(1, 0, 1, 32'h204, 32'h00A0_0093);
    checkOutput("flush_id_instr", ID_instr, 32'h13);
    checkOutput("flush_id_valid", ID_valid, 0);
    checkOutput("flush_id_pc_held", ID_PC, 32'h200);
    checkOutput("flush_ex_valid", EX_valid, 0);
    checkOutput("flush_state", state_o, 2'b10);
    checkOutput("flush_cnt_1", flush_cnt, PERF ? 1 : 0);

    applyStimulus(1, 1, 1, 32'h208, 32'h0000_0033);
    checkOutput("flushnoop_state", state_o, 2'b10);
    checkOutput("flushnoop_proto", proto_err, 0);
    checkOutput("flushnoop_stall_cnt", stall_cnt, 0);
    checkOutput("flushnoop_flush_cnt", flush_cnt, PERF ? 2 : 0);

    applyStimulus(1, 0, 0, 32'h300, 32'h0020_0113);
    checkOutput("after_flush_state", state_o, 0);
    checkOutput("after_flush_id_valid", ID_valid, 1);
    checkOutput("after_flush_ex_bubble", EX_valid, 0);

    applyStimulus(0, 0, 1, 32'h304, 32'h0030_0193);
    checkOutput("flushhold_id_valid", ID_valid, 0);
    checkOutput("flushhold_id_instr", ID_instr, 32'h13);
    checkOutput("flushhold_id_pc", ID_PC, 32'h300);
    checkOutput("flushhold_flush_cnt", flush_cnt, PERF ? 3 : 0);

    applyStimulus(1, 0, 0, 32'h400, 32'h0040_0213);
    applyStimulus(0, 1, 0, 32'h404, 32'h0);
    checkOutput("stall1_state", state_o, 2'b01);
    checkOutput("stall1_proto", proto_err, 0);
    applyStimulus(0, 1, 0, 32'h404, 32'h0);
    checkOutput("stall2_proto", proto_err, 1);
    checkOutput("stall2_stall_cnt", stall_cnt, PERF ? 2 : 0);

    applyStimulus(1, 0, 0, 32'h408, 32'h0);
    checkOutput("stall2_sticky", proto_err, 1);

    #3 rst_i = 1'b1;
    #1;
    checkOutput("rst2_proto", proto_err, 0);
    rst_i = 1'b0;

    applyStimulus(1, 1, 0, 32'h500, 32'h0050_0293);
    checkOutput("noopwrite_proto", proto_err, 1);
    checkOutput("noopwrite_state", state_o, 2'b01);
    applyStimulus(1, 0, 0, 32'h504, 32'h0);
    checkOutput("noopwrite_sticky", proto_err, 1);
    checkOutput("noopwrite_state_run", state_o, 0);

`ifdef HAZ_PERF_CNT_EN
    #3 rst_i = 1'b1;
    #1 rst_i = 1'b0;
    IF_ID_write = 1'b0; NoOp = 1'b1; Flush = 1'b0;
    repeat ((1 << CNT_W) + 3) @(posedge clk_i);
    #1;
    checkOutput("stall_cnt_saturate", stall_cnt, {CNT_W{1'b1}});
    checkOutput("flush_cnt_idle", flush_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
